lcd_scanout: RTL and testbench
==============================

LCD_SCANOUT -- requirements
Module: lcd_scanout

Interface
REQ-001 Parameter VIS_COLS, default 96, visible columns scanned per row (1..132).
REQ-002 Parameter VIS_ROWS, default 64, visible rows scanned per frame (1..64).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  single-cycle request to scan one frame.
REQ-006 display_enabled  input  1  display on; 0 forces blank output.
REQ-007 all_pixels_on  input  1  force every pixel to 1.
REQ-008 invert_pixels  input  1  invert framebuffer bits.
REQ-009 row_order  input  1  1 = rows scanned bottom-to-top.
REQ-010 start_line  input  6  scanline offset, wraps modulo 64.
REQ-011 fb_read  output  1  framebuffer read strobe.
REQ-012 fb_addr  output  11  framebuffer byte address, page*132+column.
REQ-013 fb_data  input  8  read data, valid the cycle after fb_read.
REQ-014 pix_valid / pix_ready  output / input  1 each  pixel handshake.
REQ-015 pix_data  output  1  pixel value, 1 = dark.
REQ-016 pix_first / pix_eol / pix_last  output  1 each  first pixel of frame / last column of row / last pixel of frame, qualified by pix_valid.
REQ-017 busy  output  1  frame scan in progress.
REQ-018 frame_overrun  output  1  one-cycle pulse when frame_start is dropped.
REQ-019 frame_count  output  16  completed-frame counter.

Function
REQ-020 Scan order SHALL be row-major: row 0..VIS_ROWS-1, column 0..VIS_COLS-1.
REQ-021 Source line SHALL be (start_line + (row_order ? 63-row : row)) mod 64; page = line[5:3], bit = line[2:0]; fb_addr = page*132 + column, 11-bit.
REQ-022 display_enabled, all_pixels_on, invert_pixels, row_order and start_line SHALL be latched when frame_start is accepted; mid-frame changes have no effect until the next frame.
REQ-023 pix_data SHALL be 0 if disabled, else 1 if all_pixels_on, else fb bit XOR invert_pixels.
REQ-024 FSM states: IDLE, FETCH, WAIT, OUT.
REQ-025 IDLE: on frame_start, latch config, clear counters, go FETCH (go OUT if latched display_enabled=0).
REQ-026 FETCH: fb_read=1 with valid fb_addr for one cycle, go WAIT.
REQ-027 WAIT: capture selected bit of fb_data, go OUT.
REQ-028 OUT: pix_valid=1; pix_data and markers held stable until pix_ready; on transfer advance column (wrap to 0, row+1), go FETCH (OUT if disabled), or IDLE after the last pixel.
REQ-029 Latency: frame_start sampled at edge k -> fb_read high in cycle k+1 -> pix_valid high in cycle k+3.
REQ-030 No fb_read SHALL be issued when latched display_enabled=0, nor outside FETCH.
REQ-031 frame_start while busy SHALL be ignored and pulse frame_overrun for one cycle.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 frame_count SHALL increment, wrapping at 16 bits, on transfer of the pix_last pixel.

Reset
REQ-034 reset SHALL force IDLE and all outputs to 0 (frame_count 0) on the next edge, including mid-frame; the interrupted frame is abandoned.

Configuration
REQ-035 Macro LCD_SCANOUT_FRAME_COUNT_EN defined: frame_count per REQ-033.
REQ-036 Macro undefined: frame_count tied to 0, no counter flops.

Structure
REQ-037 Package lcd_pkg SHALL hold LCD_RAM_COLS=132, LCD_ADDR_W=11, the scanout state enum typedef and a lcd_scan_cfg_t struct of the latched config.
REQ-038 Sub-module lcd_scan_addr SHALL compute fb_addr and bit index combinationally from row, column and latched config.

Verification
REQ-039 FB all 0 except addr 0=0x01; start_line 0, enabled -> pixel 0 = 1 with pix_first, the other 6143 pixels 0, pix_last on pixel 6143, frame_count 1.
REQ-040 start_line=8 -> first fb_addr=132; start_line=60, row 4 -> fb_addr=0+column, bit 0.
REQ-041 row_order=1, start_line=0 -> first fb_addr=924, bit 7 selected.
REQ-042 pix_ready low 10 cycles mid-row -> pix_data/markers stable, no fb_read until transfer.
REQ-043 display_enabled=0 -> 6144 zero pixels, fb_read never high; enabled with all_pixels_on=1, invert_pixels=1 -> all pixels 1.
REQ-044 frame_start during busy -> frame ignored, frame_overrun pulse; reset mid-frame -> pix_valid=0, busy=0 next cycle.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, scanout state encoding and latched frame configuration.
package lcd_pkg;
    localparam int LCD_RAM_COLS = 132;
    localparam int LCD_ADDR_W   = 11;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, OUT} scan_state_t;

    typedef struct packed {
        logic       enabled;
        logic       all_on;
        logic       invert;
        logic       row_order;
        logic [5:0] start_line;
    } lcd_scan_cfg_t;
endpackage

// File: rtl/lcd_scan_addr.sv
// lcd_scan_addr: maps a scan row/column to framebuffer byte address and bit index.
module lcd_scan_addr
    import lcd_pkg::*;
(
    input  logic [5:0]            i_row,
    input  logic [7:0]            i_col,
    input  lcd_scan_cfg_t         i_cfg,
    output logic [LCD_ADDR_W-1:0] o_addr,
    output logic [2:0]            o_bit
);
    logic [5:0] w_line;

    // 6-bit arithmetic gives the modulo-64 wrap of the scanline for free
    assign w_line = i_cfg.start_line + (i_cfg.row_order ? 6'd63 - i_row : i_row);
    assign o_addr = LCD_ADDR_W'(w_line[5:3]) * LCD_ADDR_W'(LCD_RAM_COLS) + LCD_ADDR_W'(i_col);
    assign o_bit  = w_line[2:0];
endmodule

// File: rtl/lcd_scanout.sv
// lcd_scanout: reads a paged LCD framebuffer and streams one pixel per handshake.
// Define LCD_SCANOUT_FRAME_COUNT_EN to build the completed-frame counter.
module lcd_scanout
    import lcd_pkg::*;
#(
    parameter int VIS_COLS = 96,
    parameter int VIS_ROWS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  display_enabled,
    input  logic                  all_pixels_on,
    input  logic                  invert_pixels,
    input  logic                  row_order,
    input  logic [5:0]            start_line,
    output logic                  fb_read,
    output logic [LCD_ADDR_W-1:0] fb_addr,
    input  logic [7:0]            fb_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_data,
    output logic                  pix_first,
    output logic                  pix_eol,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  frame_overrun,
    output logic [15:0]           frame_count
);
    scan_state_t           r_state, w_next;
    lcd_scan_cfg_t         r_cfg;
    logic [5:0]            r_row;
    logic [7:0]            r_col;
    logic                  r_pix, r_overrun;
    logic [LCD_ADDR_W-1:0] w_addr;
    logic [2:0]            w_bit;
    logic                  w_xfer, w_eol, w_last_row;

    lcd_scan_addr u_addr (
        .i_row  (r_row),
        .i_col  (r_col),
        .i_cfg  (r_cfg),
        .o_addr (w_addr),
        .o_bit  (w_bit)
    );

    assign w_xfer     = (r_state == OUT) && pix_ready;
    assign w_eol      = r_col == 8'(VIS_COLS - 1);
    assign w_last_row = r_row == 6'(VIS_ROWS - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_start) w_next = display_enabled ? FETCH : OUT;
            FETCH:   w_next = WAIT;
            WAIT:    w_next = OUT;
            OUT:     if (pix_ready) w_next = (w_eol && w_last_row) ? IDLE : (r_cfg.enabled ? FETCH : OUT);
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cfg     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_pix     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_overrun <= frame_start && (r_state != IDLE);
            if (r_state == IDLE && frame_start) begin
                r_cfg <= '{enabled: display_enabled, all_on: all_pixels_on, invert: invert_pixels,
                           row_order: row_order, start_line: start_line};
                r_row <= '0;
                r_col <= '0;
                r_pix <= 1'b0;
            end
            if (r_state == WAIT)
                r_pix <= r_cfg.all_on | (fb_data[w_bit] ^ r_cfg.invert);
            if (w_xfer) begin
                r_col <= w_eol ? 8'd0 : r_col + 8'd1;
                if (w_eol) r_row <= r_row + 6'd1;
            end
        end
    end

`ifdef LCD_SCANOUT_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (reset) r_frame_count <= '0;
        else if (w_xfer && w_eol && w_last_row) r_frame_count <= r_frame_count + 16'd1;
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = '0;
`endif

    assign fb_read       = r_state == FETCH;
    assign fb_addr       = fb_read ? w_addr : '0;
    assign pix_valid     = r_state == OUT;
    assign pix_data      = pix_valid & r_cfg.enabled & r_pix;
    assign pix_first     = pix_valid && r_row == 6'd0 && r_col == 8'd0;
    assign pix_eol       = pix_valid && w_eol;
    assign pix_last      = pix_valid && w_eol && w_last_row;
    assign busy          = r_state != IDLE;
    assign frame_overrun = r_overrun;
endmodule

// File: tb/tb_lcd_scanout.sv
// tb_lcd_scanout: table-driven first-pixel vectors plus full-frame, stall and overrun sequences.
module tb_lcd_scanout;
`ifdef LCD_SCANOUT_FRAME_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, frame_start, display_enabled, all_pixels_on, invert_pixels, row_order;
    logic [5:0]  start_line;
    logic        fb_read;
    logic [10:0] fb_addr;
    logic [7:0]  fb_data;
    logic        pix_valid, pix_ready, pix_data, pix_first, pix_eol, pix_last, busy, frame_overrun;
    logic [15:0] frame_count;
    logic [7:0]  fb [0:2047];

    int checks = 0;
    int passed = 0;

    int npix, ones, firsts, eols, lasts, last_idx, reads, first_ok;

    typedef struct {
        logic        en, ao, inv, ro;
        logic [5:0]  sl;
        logic [10:0] addr;
        logic [2:0]  bitn;
    } vec_t;
    vec_t vt [8];

    lcd_scanout dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .display_enabled (display_enabled),
        .all_pixels_on   (all_pixels_on),
        .invert_pixels   (invert_pixels),
        .row_order       (row_order),
        .start_line      (start_line),
        .fb_read         (fb_read),
        .fb_addr         (fb_addr),
        .fb_data         (fb_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_data        (pix_data),
        .pix_first       (pix_first),
        .pix_eol         (pix_eol),
        .pix_last        (pix_last),
        .busy            (busy),
        .frame_overrun   (frame_overrun),
        .frame_count     (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) fb_data <= fb[fb_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic en, input logic ao, input logic inv, input logic ro, input logic [5:0] sl);
        display_enabled = en;
        all_pixels_on   = ao;
        invert_pixels   = inv;
        row_order       = ro;
        start_line      = sl;
        frame_start     = 1'b1;
        tick;
        frame_start     = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic clear_fb;
        for (int i = 0; i < 2048; i++) fb[i] = 8'h00;
    endtask

    task automatic run_full(input bit poke);
        npix = 0; ones = 0; firsts = 0; eols = 0; lasts = 0; last_idx = -1; reads = 0; first_ok = 0;
        for (int c = 0; c < 30000; c++) begin
            if (!busy) break;
            if (poke && c == 501) check("overrun_pulse", frame_overrun, 1);
            if (poke && c == 502) check("overrun_one_cycle", frame_overrun, 0);
            frame_start = poke && c == 500;
            if (fb_read) reads++;
            if (pix_valid && pix_ready) begin
                if (npix == 0) first_ok = pix_data & pix_first;
                if (pix_data) ones++;
                if (pix_first) firsts++;
                if (pix_eol) eols++;
                if (pix_last) begin
                    lasts++;
                    last_idx = npix;
                end
                npix++;
            end
            tick;
        end
        frame_start = 1'b0;
        check("frame_done", busy, 0);
    endtask

    initial begin
        int idx;
        int stall_bad;
        logic exp_pix, d0, f0, e0, l0;
        bit stalled;

        reset = 1'b1; frame_start = 1'b0; display_enabled = 1'b0; all_pixels_on = 1'b0;
        invert_pixels = 1'b0; row_order = 1'b0; start_line = 6'd0; pix_ready = 1'b0;
        clear_fb;
        tick; tick;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_fb_read", fb_read, 0);
        check("rst_overrun", frame_overrun, 0);
        check("rst_count", frame_count, 0);

        fb[0] = 8'h10; fb[132] = 8'h01; fb[924] = 8'h90; fb[264] = 8'h02;
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  11'd0,   3'd0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd8,  11'd132, 3'd0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd0,  11'd924, 3'd7};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd60, 11'd924, 3'd4};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd5,  11'd0,   3'd4};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd63, 11'd924, 3'd7};
        vt[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd17, 11'd264, 3'd1};
        vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd9,  11'd0,   3'd0};
        for (int i = 0; i < 8; i++) begin
            start(vt[i].en, vt[i].ao, vt[i].inv, vt[i].ro, vt[i].sl);
            check($sformatf("v%0d_fb_read", i), fb_read, vt[i].en);
            check($sformatf("v%0d_fb_addr", i), fb_addr, vt[i].addr);
            tick; tick;
            exp_pix = vt[i].en & (vt[i].ao | (fb[vt[i].addr][vt[i].bitn] ^ vt[i].inv));
            check($sformatf("v%0d_pix_valid", i), pix_valid, 1);
            check($sformatf("v%0d_pix_data", i), pix_data, exp_pix);
            check($sformatf("v%0d_pix_first", i), pix_first, 1);
            do_reset;
            check($sformatf("v%0d_rst_busy", i), busy, 0);
            check($sformatf("v%0d_rst_valid", i), pix_valid, 0);
        end

        clear_fb;
        fb[5] = 8'h01; fb[932] = 8'h40;
        start(1'b1, 1'b0, 1'b0, 1'b0, 6'd60);
        pix_ready = 1'b1;
        idx = 0; stalled = 1'b0; stall_bad = 0;
        for (int c = 0; c < 3000 && idx < 400; c++) begin
            if (fb_read && idx == 384) check("row4_addr_col0", fb_addr, 0);
            if (fb_read && idx == 389) check("row4_addr_col5", fb_addr, 5);
            if (pix_valid && idx == 200 && !stalled) begin
                d0 = pix_data; f0 = pix_first; e0 = pix_eol; l0 = pix_last;
                check("stall_pix", d0, 1);
                pix_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    tick;
                    if (fb_read || !pix_valid || pix_data !== d0 || pix_first !== f0 || pix_eol !== e0 || pix_last !== l0)
                        stall_bad++;
                end
                pix_ready = 1'b1;
                stalled = 1'b1;
                check("stall_stable", stall_bad, 0);
            end
            if (pix_valid && pix_ready) begin
                if (idx == 388) check("row4_pix_col4", pix_data, 0);
                if (idx == 389) check("row4_pix_col5", pix_data, 1);
                idx++;
            end
            tick;
        end
        check("row4_reached", idx, 400);
        do_reset;

        clear_fb;
        fb[0] = 8'h01;
        start(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        invert_pixels = 1'b1; start_line = 6'd8; row_order = 1'b1;
        run_full(1'b1);
        check("fa_npix", npix, 6144);
        check("fa_ones", ones, 1);
        check("fa_first_pixel", first_ok, 1);
        check("fa_firsts", firsts, 1);
        check("fa_eols", eols, 64);
        check("fa_lasts", lasts, 1);
        check("fa_last_idx", last_idx, 6143);
        check("fa_reads", reads, 6144);
        check("fa_count", frame_count, FC_EN ? 1 : 0);

        start(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        display_enabled = 1'b1;
        run_full(1'b0);
        check("fd_npix", npix, 6144);
        check("fd_ones", ones, 0);
        check("fd_reads", reads, 0);
        check("fd_count", frame_count, FC_EN ? 2 : 0);

        start(1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        all_pixels_on = 1'b0;
        run_full(1'b0);
        check("fo_npix", npix, 6144);
        check("fo_ones", ones, 6144);
        check("fo_count", frame_count, FC_EN ? 3 : 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
